// File: rtl/controle_fuzzy.sv
// Sequencer for the type-2 trapezoidal fuzzy processor: strobes each stage in turn and aborts when no rule can fire.
// Optional feature macro FUZZY_CONTADOR_EN adds the saturating AMOSTRAS completion counter.
module controle_fuzzy #(
    parameter int LAT_FUZ = 2,
    parameter int LAT_INF = 3,
    parameter int LAT_RED = 8,
    parameter int LAT_DEF = 4,
    parameter int CNT_W   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [5:0] Ativo_UP,
    output logic       EN_Fuzzificador,
    output logic       EN_Inferencia,
    output logic       EN_Reducao,
    output logic       EN_Defuzzificador,
    output logic       BUSY,
    output logic       DONE,
`ifdef FUZZY_CONTADOR_EN
    output logic       SEM_REGRA,
    output logic [15:0] AMOSTRAS
`else
    output logic       SEM_REGRA
`endif
);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        FUZZ   = 3'd1,
        INFER  = 3'd2,
        REDUC  = 3'd3,
        DEFUZ  = 3'd4,
        FIM    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CARGA_FUZ = CNT_W'(LAT_FUZ - 1);
    localparam logic [CNT_W-1:0] CARGA_INF = CNT_W'(LAT_INF - 1);
    localparam logic [CNT_W-1:0] CARGA_RED = CNT_W'(LAT_RED - 1);
    localparam logic [CNT_W-1:0] CARGA_DEF = CNT_W'(LAT_DEF - 1);
    localparam logic [CNT_W-1:0] UM        = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             sem_regra_ativa;

    assign cnt_zero        = (cnt == '0);
    // A rule needs at least one active term on each input
    assign sem_regra_ativa = (Ativo_UP[5:3] == 3'b000) || (Ativo_UP[2:0] == 3'b000);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state             <= OCIOSO;
            cnt               <= '0;
            EN_Fuzzificador   <= 1'b0;
            EN_Inferencia     <= 1'b0;
            EN_Reducao        <= 1'b0;
            EN_Defuzzificador <= 1'b0;
            BUSY              <= 1'b0;
            DONE              <= 1'b0;
            SEM_REGRA         <= 1'b0;
        end else begin
            EN_Fuzzificador   <= 1'b0;
            EN_Inferencia     <= 1'b0;
            EN_Reducao        <= 1'b0;
            EN_Defuzzificador <= 1'b0;
            DONE              <= 1'b0;
            case (state)
                OCIOSO: begin
                    if (START) begin
                        state           <= FUZZ;
                        cnt             <= CARGA_FUZ;
                        EN_Fuzzificador <= 1'b1;
                        BUSY            <= 1'b1;
                        SEM_REGRA       <= 1'b0;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                FUZZ: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - UM;
                    end else if (sem_regra_ativa) begin
                        state     <= FIM;
                        DONE      <= 1'b1;
                        SEM_REGRA <= 1'b1;
                    end else begin
                        state         <= INFER;
                        cnt           <= CARGA_INF;
                        EN_Inferencia <= 1'b1;
                    end
                end
                INFER: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - UM;
                    end else begin
                        state      <= REDUC;
                        cnt        <= CARGA_RED;
                        EN_Reducao <= 1'b1;
                    end
                end
                REDUC: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - UM;
                    end else begin
                        state             <= DEFUZ;
                        cnt               <= CARGA_DEF;
                        EN_Defuzzificador <= 1'b1;
                    end
                end
                DEFUZ: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - UM;
                    end else begin
                        state <= FIM;
                        DONE  <= 1'b1;
                    end
                end
                FIM: begin
                    state <= OCIOSO;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= OCIOSO;
                    cnt   <= '0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FUZZY_CONTADOR_EN
    // Counts only completions that reach FIM through DEFUZ; aborted runs bypass it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            AMOSTRAS <= 16'h0000;
        end else if (state == DEFUZ && cnt_zero && AMOSTRAS != 16'hFFFF) begin
            AMOSTRAS <= AMOSTRAS + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_controle_fuzzy.sv
// Scoreboard bench for controle_fuzzy: per-cycle expected output vectors are queued at launch and popped each edge.
module tb_controle_fuzzy;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start2;
    logic [5:0] ativo;
    logic       en_f, en_i, en_r, en_d, busy, done, sem;
    logic       en_f2, en_i2, en_r2, en_d2, busy2, done2, sem2;
`ifdef FUZZY_CONTADOR_EN
    logic [15:0] amostras;
    logic [15:0] amostras2;
`endif

    int errors = 0;
    int checks = 0;
    logic [6:0] exp_q[$];

    controle_fuzzy dut (
        .CLK(clk), .RESET(rst), .START(start), .Ativo_UP(ativo),
        .EN_Fuzzificador(en_f), .EN_Inferencia(en_i), .EN_Reducao(en_r),
        .EN_Defuzzificador(en_d), .BUSY(busy), .DONE(done),
`ifdef FUZZY_CONTADOR_EN
        .SEM_REGRA(sem), .AMOSTRAS(amostras)
`else
        .SEM_REGRA(sem)
`endif
    );

    controle_fuzzy #(.LAT_FUZ(2), .LAT_INF(3), .LAT_RED(1), .LAT_DEF(1), .CNT_W(4)) dut2 (
        .CLK(clk), .RESET(rst), .START(start2), .Ativo_UP(ativo),
        .EN_Fuzzificador(en_f2), .EN_Inferencia(en_i2), .EN_Reducao(en_r2),
        .EN_Defuzzificador(en_d2), .BUSY(busy2), .DONE(done2),
`ifdef FUZZY_CONTADOR_EN
        .SEM_REGRA(sem2), .AMOSTRAS(amostras2)
`else
        .SEM_REGRA(sem2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] obs1();
        return {en_f, en_i, en_r, en_d, busy, done, sem};
    endfunction

    function automatic logic [6:0] obs2();
        return {en_f2, en_i2, en_r2, en_d2, busy2, done2, sem2};
    endfunction

    // Expected vector layout: {EN_F, EN_I, EN_R, EN_D, BUSY, DONE, SEM_REGRA}
    task automatic push_stage(input int lat, input int which);
        for (int c = 0; c < lat; c++) begin
            logic [6:0] v;
            v = 7'b0000_100;
            if (c == 0) v[6 - which] = 1'b1;
            exp_q.push_back(v);
        end
    endtask

    task automatic push_run(input int lf, input int li, input int lr, input int ld, input bit abort);
        push_stage(lf, 0);
        if (abort) begin
            exp_q.push_back(7'b0000_111);
        end else begin
            push_stage(li, 1);
            push_stage(lr, 2);
            push_stage(ld, 3);
            exp_q.push_back(7'b0000_110);
        end
    endtask

    task automatic push_idle(input bit s);
        exp_q.push_back({6'b000000, s});
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; ativo = 6'b000000;
        #12;
        checks++;
        if (obs1() !== 7'b0) begin
            errors++;
            $display("FAIL reset_dut outputs=%b expected=%b", obs1(), 7'b0);
        end
        checks++;
        if (obs2() !== 7'b0) begin
            errors++;
            $display("FAIL reset_dut2 outputs=%b expected=%b", obs2(), 7'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal_run();
        ativo = 6'b000000;
        start = 1'b1;
        push_run(2, 3, 8, 4, 1'b0);
        push_idle(1'b0);
        for (int k = 1; exp_q.size() > 0; k++) begin
            logic [6:0] e;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL normal_run edge=%0d outputs=%b expected=%b", k, obs1(), e);
            end
            if (k == 1) start = 1'b0;
            if (k == 2) ativo = 6'b010_001;
            if (k == 3) ativo = 6'b000_000;
        end
    endtask

    task automatic test_abort();
        ativo = 6'b000_011;
        start = 1'b1;
        push_run(2, 3, 8, 4, 1'b1);
        push_idle(1'b1);
        push_idle(1'b1);
        push_idle(1'b1);
        for (int k = 1; exp_q.size() > 0; k++) begin
            logic [6:0] e;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL abort edge=%0d outputs=%b expected=%b", k, obs1(), e);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        ativo = 6'b100_100;
        start = 1'b1;
        push_run(2, 3, 8, 4, 1'b0);
        push_idle(1'b0);
        push_run(2, 3, 8, 4, 1'b0);
        push_idle(1'b0);
        push_idle(1'b0);
        for (int k = 1; exp_q.size() > 0; k++) begin
            logic [6:0] e;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL back_to_back edge=%0d outputs=%b expected=%b", k, obs1(), e);
            end
            if (k == 25) start = 1'b0;
            if (k == 27) start = 1'b1;
            if (k == 29) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        ativo = 6'b001_010;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
        end
        checks++;
        if (obs1() !== 7'b0000_100) begin
            errors++;
            $display("FAIL mid_reduc_before_reset outputs=%b expected=%b", obs1(), 7'b0000_100);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs1() !== 7'b0) begin
            errors++;
            $display("FAIL async_reset outputs=%b expected=%b", obs1(), 7'b0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs1() !== 7'b0) begin
            errors++;
            $display("FAIL reset_held outputs=%b expected=%b", obs1(), 7'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL after_reset_quiet cycle=%0d busy=%b done=%b expected 0 0", k, busy, done);
            end
        end
        start = 1'b1;
        push_run(2, 3, 8, 4, 1'b0);
        push_idle(1'b0);
        for (int k = 1; exp_q.size() > 0; k++) begin
            logic [6:0] e;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL run_after_reset edge=%0d outputs=%b expected=%b", k, obs1(), e);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_short_latency();
        ativo = 6'b111_111;
        start2 = 1'b1;
        push_run(2, 3, 1, 1, 1'b0);
        push_idle(1'b0);
        for (int k = 1; exp_q.size() > 0; k++) begin
            logic [6:0] e;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs2() !== e) begin
                errors++;
                $display("FAIL short_latency edge=%0d outputs=%b expected=%b", k, obs2(), e);
            end
            checks++;
            if ($countones({en_f2, en_i2, en_r2, en_d2}) > 1) begin
                errors++;
                $display("FAIL strobe_overlap edge=%0d strobes=%b expected at most one high", k,
                         {en_f2, en_i2, en_r2, en_d2});
            end
            if (k == 1) start2 = 1'b0;
        end
    endtask

`ifdef FUZZY_CONTADOR_EN
    task automatic launch_run(input logic [5:0] a);
        ativo = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_contador();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(negedge clk);
        launch_run(6'b001_001);
        launch_run(6'b010_100);
        launch_run(6'b000_111);
        launch_run(6'b100_010);
        checks++;
        if (amostras !== 16'd3) begin
            errors++;
            $display("FAIL contador_count amostras=%0d expected=%0d", amostras, 3);
        end
        force dut.AMOSTRAS = 16'hFFFE;
        #1;
        release dut.AMOSTRAS;
        @(negedge clk);
        for (int r = 0; r < 3; r++) launch_run(6'b011_011);
        checks++;
        if (amostras !== 16'hFFFF) begin
            errors++;
            $display("FAIL contador_saturate amostras=%h expected=%h", amostras, 16'hFFFF);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal_run();
        test_abort();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_short_latency();
`ifdef FUZZY_CONTADOR_EN
        test_contador();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
